// File: rtl/ql_cfg_pkg.sv
// Shared types and helpers for the bit-line/word-line configuration loader.
// Latency: n/a (types, constants and a constant function only).
// Backpressure: n/a.
// Contents: cfg_state_t FSM encoding, default widths, words_per_row().
package ql_cfg_pkg;

    localparam int unsigned DEF_BL_WIDTH = 514;
    localparam int unsigned DEF_WL_WIDTH = 407;
    localparam int unsigned DEF_IN_WIDTH = 32;
    localparam int unsigned DEF_WL_PULSE = 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SETUP = 3'd2,
        PULSE = 3'd3,
        HOLD  = 3'd4,
        DONE  = 3'd5
    } cfg_state_t;

    // Bitstream words needed to cover one row of bit lines (ceiling divide).
    function automatic int unsigned words_per_row(input int unsigned bl_width,
                                                  input int unsigned in_width);
        return (bl_width + in_width - 1) / in_width;
    endfunction

endpackage

// File: rtl/ql_cfg_bl_wl_loader_if.sv
// Bitstream word stream into the configuration loader.
// Latency: n/a (wires only).
// Backpressure: plain valid/ready; a word moves when s_valid && s_ready.
// Signals: s_data (bitstream word), s_valid (source has a word), s_ready (loader takes it).
interface ql_cfg_bl_wl_loader_if
    import ql_cfg_pkg::*;
#(
    parameter int unsigned IN_WIDTH = DEF_IN_WIDTH
);

    logic [IN_WIDTH-1:0] s_data;
    logic                s_valid;
    logic                s_ready;

    modport master (
        output s_data,
        output s_valid,
        input  s_ready
    );

    modport slave (
        input  s_data,
        input  s_valid,
        output s_ready
    );

endinterface

// File: rtl/ql_cfg_row_assembler.sv
// Row register for one bit-line row, filled word by word from the bitstream.
// Latency: a written word appears on bl the cycle after wr_en.
// Backpressure: none; the caller only raises wr_en on an accepted transfer.
// Ports: clk, reset, clr (restart at word 0), wr_en, wr_data in; bl (row), last_word out.
module ql_cfg_row_assembler
    import ql_cfg_pkg::*;
#(
    parameter int unsigned BL_WIDTH = DEF_BL_WIDTH,
    parameter int unsigned IN_WIDTH = DEF_IN_WIDTH
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clr,
    input  logic                wr_en,
    input  logic [IN_WIDTH-1:0] wr_data,
    output logic [0:BL_WIDTH-1] bl,
    output logic                last_word
);

    localparam int unsigned WPR    = words_per_row(BL_WIDTH, IN_WIDTH);
    localparam int unsigned WORD_W = (WPR > 1) ? $clog2(WPR) : 1;

    logic [WORD_W-1:0]   word;
    logic [0:BL_WIDTH-1] row;
    logic [0:BL_WIDTH-1] row_nxt;

    assign last_word = (word == WORD_W'(WPR - 1));

    // Bit i of the row belongs to word i/IN_WIDTH, bit i%IN_WIDTH. Bits of
    // the final word that fall past BL_WIDTH have no destination and drop out.
    for (genvar i = 0; i < BL_WIDTH; i++) begin : g_map
        assign row_nxt[i] = (word == WORD_W'(i / IN_WIDTH)) ? wr_data[i % IN_WIDTH] : row[i];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            row <= '0;
        end else if (wr_en) begin
            row <= row_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            word <= '0;
        end else if (wr_en) begin
            word <= last_word ? '0 : word + 1'b1;
        end
    end

    assign bl = row;

endmodule

// File: rtl/ql_cfg_bl_wl_loader.sv
// Loads the BL/WL configuration memory: assembles each row, then strobes its word line.
// Latency: WPR + 2 + WL_PULSE cycles per row at full input rate; all outputs registered.
// Backpressure: s_ready only in LOAD; s_valid gaps stall the row, never drop words.
// Ports: clk, reset, start; s (bitstream slave); bl, wl (config buses); busy, done (status).
module ql_cfg_bl_wl_loader
    import ql_cfg_pkg::*;
#(
    parameter int unsigned BL_WIDTH = DEF_BL_WIDTH,
    parameter int unsigned WL_WIDTH = DEF_WL_WIDTH,
    parameter int unsigned IN_WIDTH = DEF_IN_WIDTH,
    parameter int unsigned WL_PULSE = DEF_WL_PULSE
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    ql_cfg_bl_wl_loader_if.slave   s,
    output logic [0:BL_WIDTH-1]    bl,
    output logic [0:WL_WIDTH-1]    wl,
    output logic                   busy,
    output logic                   done
);

    localparam int unsigned ROW_W  = (WL_WIDTH > 1) ? $clog2(WL_WIDTH) : 1;
    localparam int unsigned PCNT_W = (WL_PULSE > 1) ? $clog2(WL_PULSE) : 1;

    cfg_state_t          state;
    logic [ROW_W-1:0]    row;
    logic [PCNT_W-1:0]   pcnt;
    logic [0:WL_WIDTH-1] wl_dec;
    logic                xfer;
    logic                start_ok;
    logic                last_word;

    // s_ready is a registered copy of "in LOAD", so a transfer is only ever
    // seen while the row register is allowed to change.
    assign xfer     = s.s_valid && s.s_ready;
    assign start_ok = start && ((state == IDLE) || (state == DONE));

    for (genvar i = 0; i < WL_WIDTH; i++) begin : g_wl_dec
        assign wl_dec[i] = (row == ROW_W'(i));
    end

    ql_cfg_row_assembler #(
        .BL_WIDTH (BL_WIDTH),
        .IN_WIDTH (IN_WIDTH)
    ) u_row (
        .clk       (clk),
        .reset     (reset),
        .clr       (start_ok),
        .wr_en     (xfer),
        .wr_data   (s.s_data),
        .bl        (bl),
        .last_word (last_word)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            row       <= '0;
            pcnt      <= '0;
            s.s_ready <= 1'b0;
            wl        <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state     <= LOAD;
                        row       <= '0;
                        s.s_ready <= 1'b1;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                    end
                end
                LOAD: begin
                    if (xfer && last_word) begin
                        state     <= SETUP;
                        s.s_ready <= 1'b0;
                    end
                end
                SETUP: begin
                    // bl has been stable for this whole cycle; raise the strobe.
                    state <= PULSE;
                    pcnt  <= '0;
                    wl    <= wl_dec;
                end
                PULSE: begin
                    if (pcnt == PCNT_W'(WL_PULSE - 1)) begin
                        state <= HOLD;
                        wl    <= '0;
                    end else begin
                        pcnt <= pcnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (row == ROW_W'(WL_WIDTH - 1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state     <= LOAD;
                        row       <= row + 1'b1;
                        s.s_ready <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
